// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package arb_pkg;

  // Width of the IF starvation counter.
  localparam int STARVE_W = 4;

  // Width of the memory-latency down-counter. It must hold MEM_LAT values up to 4.
  localparam int LAT_W = 3;

  // Sequencer state: IDLE means the memory port is free, BUSY means an access is in flight.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Which requester owns the access in flight, or which requester won arbitration.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  // Increment that stops at lim instead of wrapping.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? lim : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_pick.sv
// Combinational priority picker. LSU normally wins. IF wins once it has waited
// through STARVE_MAX LSU grants. IF is never eligible while the pipeline flushes.
module arb_pick
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                en_i,
  input  logic                if_req_i,
  input  logic                lsu_req_i,
  input  logic                flush_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output owner_e              winner_o
);

  logic if_ok;
  logic starved;

  assign if_ok   = if_req_i & ~flush_i;
  assign starved = (starve_cnt_i == STARVE_W'(STARVE_MAX));

  // Select the winner for this arbitration slot.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    winner_o = OWN_NONE;
    if (en_i) begin
      if (if_ok && starved) begin
        winner_o = OWN_IF;
      end else if (lsu_req_i) begin
        winner_o = OWN_LSU;
      end else if (if_ok) begin
        winner_o = OWN_IF;
      end
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter and sequencer for one synchronous memory port shared by instruction
// fetch and the load/store unit. It grants one access per MEM_LAT cycles and
// routes each response to the requester that owns the access.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        flush_i,

  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  arb_state_e          state_q,  state_d;
  logic [LAT_W-1:0]    lat_q,    lat_d;
  owner_e              owner_q,  owner_d;
  logic                cancel_q, cancel_d;
  logic                store_q,  store_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  // Low for the first cycle after reset. All outputs stay quiet in that cycle.
  logic                live_q,   live_d;

  logic   live;
  logic   last_busy;
  logic   arb_en;
  logic   complete;
  owner_e winner;
  logic   if_gnt;
  logic   lsu_gnt;
  logic   lsu_store;

  // Outputs are forced quiet while reset is applied, even before the reset edge.
  assign live      = rst_ni & live_q;
  assign last_busy = (state_q == ARB_BUSY) && (lat_q == LAT_W'(1));
  assign arb_en    = live && ((state_q == ARB_IDLE) || last_busy);
  assign complete  = live && last_busy;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .en_i         (arb_en),
    .if_req_i     (if_req_i),
    .lsu_req_i    (lsu_req_i),
    .flush_i      (flush_i),
    .starve_cnt_i (starve_q),
    .winner_o     (winner)
  );

  assign if_gnt    = (winner == OWN_IF);
  assign lsu_gnt   = (winner == OWN_LSU);
  assign lsu_store = lsu_gnt & lsu_we_i;

  assign if_gnt_o  = if_gnt;
  assign lsu_gnt_o = lsu_gnt;

  // Drive the memory port from the winner in the grant cycle. It is all zero otherwise.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    unique case (winner)
      OWN_IF: begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = if_addr_i;
      end
      OWN_LSU: begin
        mem_req_o   = 1'b1;
        mem_we_o    = lsu_we_i;
        mem_be_o    = lsu_we_i ? lsu_be_i : 4'hF;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_we_i ? lsu_wdata_i : 32'h0;
      end
      default: ;
    endcase
  end

  // Route the completing response to its owner. A cancelled IF response, or an
  // IF response in a flush cycle, produces no if_rvalid_o. A store returns rdata 0.
  always_comb begin
    if_rvalid_o  = 1'b0;
    if_rdata_o   = 32'h0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = 32'h0;
    if (complete) begin
      if (owner_q == OWN_IF && !cancel_q && !flush_i) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end
      if (owner_q == OWN_LSU) begin
        lsu_rvalid_o = 1'b1;
        lsu_rdata_o  = store_q ? 32'h0 : mem_rdata_i;
      end
    end
  end

  // Sequencer next state. Count down the access in flight, and start a new
  // access on a grant. A grant in the completion cycle overrides the return to IDLE.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    owner_d  = owner_q;
    cancel_d = cancel_q;
    store_d  = store_q;
    live_d   = 1'b1;

    if (state_q == ARB_BUSY) begin
      if (owner_q == OWN_IF && flush_i) begin
        cancel_d = 1'b1;
      end
      if (lat_q > LAT_W'(1)) begin
        lat_d = lat_q - LAT_W'(1);
      end else begin
        state_d  = ARB_IDLE;
        owner_d  = OWN_NONE;
        cancel_d = 1'b0;
        store_d  = 1'b0;
      end
    end

    if (winner != OWN_NONE) begin
      state_d  = ARB_BUSY;
      lat_d    = LAT_W'(MEM_LAT);
      owner_d  = winner;
      cancel_d = 1'b0;
      store_d  = lsu_store;
    end
  end

  // Starvation counter. It counts LSU grants that IF sat through and resets when
  // IF is served or stops asking.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt) begin
      starve_d = '0;
    end else if (lsu_gnt) begin
      starve_d = sat_inc(starve_q, STARVE_W'(STARVE_MAX));
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      lat_q    <= '0;
      owner_q  <= OWN_NONE;
      cancel_q <= 1'b0;
      store_q  <= 1'b0;
      starve_q <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      owner_q  <= owner_d;
      cancel_q <= cancel_d;
      store_q  <= store_d;
      starve_q <= starve_d;
      live_q   <= live_d;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench. It runs three arbiters (MEM_LAT = 1, 2, 3) side by side.
// Each arbiter has its own memory harness, directed scenarios, random traffic and
// a cycle-level reference model built from completion times and a reference memory.
module tb_imem_dmem_arbiter;

  localparam int NINST = 3;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit done [NINST];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Power-up contents of every memory word.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  for (genvar g = 0; g < NINST; g++) begin : g_lat
    localparam int LAT = g + 1;

    logic        rst_n, if_req, flush, lsu_req, lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] if_addr, lsu_addr, lsu_wdata;
    logic        if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata, mem_rdata;

    imem_dmem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .if_req_i     (if_req),
      .if_addr_i    (if_addr),
      .if_gnt_o     (if_gnt),
      .if_rvalid_o  (if_rvalid),
      .if_rdata_o   (if_rdata),
      .flush_i      (flush),
      .lsu_req_i    (lsu_req),
      .lsu_we_i     (lsu_we),
      .lsu_be_i     (lsu_be),
      .lsu_addr_i   (lsu_addr),
      .lsu_wdata_i  (lsu_wdata),
      .lsu_gnt_o    (lsu_gnt),
      .lsu_rvalid_o (lsu_rvalid),
      .lsu_rdata_o  (lsu_rdata),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_be_o     (mem_be),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
    );

    // Memory harness. Read data appears LAT cycles after the request. When no
    // read is returning, the data lines carry junk.
    logic [31:0] hmem [int];
    logic [31:0] rd_pipe [LAT];
    assign mem_rdata = rd_pipe[LAT-1];

    function automatic logic [31:0] hmem_rd(input logic [31:0] a);
      return hmem.exists(int'(a[31:2])) ? hmem[int'(a[31:2])] : init_word(a);
    endfunction

    always @(posedge clk) begin
      if (mem_req && mem_we) hmem[int'(mem_addr[31:2])] = merge(hmem_rd(mem_addr), mem_wdata, mem_be);
      for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= (mem_req && !mem_we) ? hmem_rd(mem_addr) : $urandom;
    end

    // Reference model state.
    int          cyc = 0;
    bit          m_ready, m_busy, m_sup, m_we;
    int          m_own, m_done, m_starve;
    logic [31:0] m_data;
    logic [31:0] rmem [int];

    // Observations that the stimulus uses.
    bit          obs_if_gnt, obs_lsu_gnt;
    int          last_if_gnt_cyc, n_if_rv, n_lsu_rv;
    logic [31:0] lsu_rv_q [$];

    function automatic string tag(input string s);
      return $sformatf("L%0d_%s", LAT, s);
    endfunction

    function automatic logic [31:0] rmem_rd(input logic [31:0] a);
      return rmem.exists(int'(a[31:2])) ? rmem[int'(a[31:2])] : init_word(a);
    endfunction

    // Runs one clock cycle. It starts just after a rising edge with the inputs
    // already driven, compares at mid-cycle, advances the model, and returns after the next edge.
    task automatic cycle();
      bit          live, fin, arb, if_ok, ex_ifv, ex_lsv, ex_we;
      int          win;
      logic [31:0] ex_ifd, ex_lsd, ex_addr;
      logic [3:0]  ex_be;
      #4;
      live   = (rst_n === 1'b1) && m_ready;
      fin    = live && m_busy && (cyc == m_done);
      ex_ifv = fin && (m_own == 1) && !m_sup && !flush;
      ex_lsv = fin && (m_own == 2);
      ex_ifd = ex_ifv ? m_data : 32'h0;
      ex_lsd = ex_lsv ? m_data : 32'h0;
      arb    = live && (!m_busy || cyc == m_done);
      if_ok  = if_req && !flush;
      win    = 0;
      if (arb) begin
        if (if_ok && m_starve == SMAX) win = 1;
        else if (lsu_req)              win = 2;
        else if (if_ok)                win = 1;
      end
      ex_we   = (win == 2) && lsu_we;
      ex_be   = (win == 0) ? 4'h0 : (ex_we ? lsu_be : 4'hF);
      ex_addr = (win == 1) ? if_addr : ((win == 2) ? lsu_addr : 32'h0);

      check(tag("gnt"), {if_gnt, lsu_gnt}, {win == 1, win == 2});
      check(tag("rvalid"), {if_rvalid, lsu_rvalid}, {ex_ifv, ex_lsv});
      check(tag("if_rdata"), if_rdata, ex_ifd);
      check(tag("lsu_rdata"), lsu_rdata, ex_lsd);
      check(tag("mem_ctl"), {mem_req, mem_we, mem_be, mem_addr}, {win != 0, ex_we, ex_be, ex_addr});
      if (ex_we)         check(tag("mem_wdata"), mem_wdata, lsu_wdata);
      else if (win == 0) check(tag("mem_wdata_idle"), mem_wdata, 32'h0);

      obs_if_gnt  = if_gnt;
      obs_lsu_gnt = lsu_gnt;
      if (if_gnt) last_if_gnt_cyc = cyc;
      if (if_rvalid) n_if_rv++;
      if (lsu_rvalid) begin
        n_lsu_rv++;
        lsu_rv_q.push_back(lsu_rdata);
      end

      if (rst_n !== 1'b1) begin
        m_ready  = 1'b0;
        m_busy   = 1'b0;
        m_starve = 0;
      end else begin
        m_ready = 1'b1;
        if (m_busy && m_own == 1 && flush) m_sup = 1'b1;
        if (fin) m_busy = 1'b0;
        if (win != 0) begin
          m_busy = 1'b1;
          m_done = cyc + LAT;
          m_own  = win;
          m_sup  = 1'b0;
          m_we   = ex_we;
          if (win == 1) m_data = rmem_rd(if_addr);
          else if (ex_we) begin
            rmem[int'(lsu_addr[31:2])] = merge(rmem_rd(lsu_addr), lsu_wdata, lsu_be);
            m_data = 32'h0;
          end else m_data = rmem_rd(lsu_addr);
        end
        if (!if_req || win == 1)          m_starve = 0;
        else if (win == 2 && m_starve < SMAX) m_starve++;
      end
      @(posedge clk);
      #1;
      cyc++;
    endtask

    task automatic idle(input int n);
      repeat (n) cycle();
    endtask

    // Keeps the present requests up until each one is granted. Bounded by budget cycles.
    task automatic serve(input int budget);
      int n;
      n = 0;
      while ((if_req || lsu_req) && n < budget) begin
        cycle();
        n++;
        if (obs_if_gnt)  if_req  = 1'b0;
        if (obs_lsu_gnt) lsu_req = 1'b0;
      end
      check(tag("serve_timeout"), {if_req, lsu_req}, 2'b00);
      if_req  = 1'b0;
      lsu_req = 1'b0;
    endtask

    initial begin
      int          t0, k, n, rv0, fc_off, exp_gap;
      logic [31:0] w;
      rst_n = 1'b0; if_req = 1'b0; flush = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
      lsu_be = 4'h0; if_addr = 32'h0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // IF-only stream.
      for (int i = 0; i < 3; i++) begin
        if_req  = 1'b1;
        if_addr = 32'(i * 4);
        serve(20);
      end
      idle(LAT + 1);

      // IF and an LSU load requested together. LSU goes first, then IF after LAT cycles.
      if_req = 1'b1; if_addr = 32'h40;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100;
      t0 = cyc;
      serve(40);
      check(tag("both_if_gnt_gap"), last_if_gnt_cyc - t0, LAT);
      idle(LAT + 1);

      // Both requesters held high. Expect 4 LSU grants, then 1 IF grant, repeating.
      if_req = 1'b1; lsu_req = 1'b1; lsu_we = 1'b0;
      k = 0; n = 0;
      while (k < 25 && n < 400) begin
        cycle();
        n++;
        if (obs_if_gnt || obs_lsu_gnt) begin
          check(tag("starve_seq"), obs_if_gnt, (k % 5) == 4);
          k++;
          if_addr  = rnd_addr();
          lsu_addr = rnd_addr();
        end
      end
      check(tag("starve_grants"), k, 25);
      if_req = 1'b0; lsu_req = 1'b0;
      idle(LAT + 1);

      // Partial store followed by a load of the same word.
      lsu_rv_q.delete();
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011;
      lsu_addr = 32'h200; lsu_wdata = 32'hDEADBEEF;
      serve(20);
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h200;
      serve(20);
      idle(LAT + 1);
      check(tag("sl_count"), lsu_rv_q.size(), 2);
      if (lsu_rv_q.size() == 2) begin
        w = init_word(32'h200);
        check(tag("store_ack_rdata"), lsu_rv_q[0], 32'h0);
        check(tag("load_after_store"), lsu_rv_q[1], {w[31:16], 16'hBEEF});
      end

      // IF access cancelled by a flush while it is in flight.
      if_req = 1'b1; if_addr = 32'h80;
      serve(20);
      t0  = cyc - 1;
      rv0 = n_if_rv;
      if_req = 1'b1; if_addr = 32'h84;
      fc_off = (LAT >= 2) ? 2 : 1;
      if (LAT >= 2) cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      serve(20);
      idle(LAT + 1);
      exp_gap = (fc_off == LAT) ? LAT + 1 : LAT;
      check(tag("flush_next_gnt"), last_if_gnt_cyc - t0, exp_gap);
      check(tag("flush_rvalids"), n_if_rv - rv0, 1);

      // Reset while an LSU load is in flight.
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h300;
      serve(20);
      rv0 = n_lsu_rv;
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(LAT + 1);
      check(tag("rst_no_rvalid"), n_lsu_rv - rv0, 0);
      if_req = 1'b1; if_addr = 32'hC0;
      t0 = cyc;
      serve(10);
      check(tag("post_rst_gnt"), last_if_gnt_cyc - t0, 0);
      idle(LAT + 1);

      // Random traffic with flushes and occasional resets.
      repeat (400) begin
        if (!if_req || obs_if_gnt) begin
          if_req  = ($urandom % 3) != 0;
          if_addr = rnd_addr();
        end else if ($urandom % 16 == 0) if_req = 1'b0;
        if (!lsu_req || obs_lsu_gnt) begin
          lsu_req   = ($urandom % 3) != 0;
          lsu_we    = ($urandom % 3) == 0;
          lsu_be    = 4'($urandom);
          lsu_addr  = rnd_addr();
          lsu_wdata = $urandom;
        end else if ($urandom % 16 == 0) lsu_req = 1'b0;
        flush = ($urandom % 8) == 0;
        rst_n = ($urandom % 150) != 0;
        cycle();
      end
      rst_n = 1'b1; flush = 1'b0; if_req = 1'b0; lsu_req = 1'b0;
      idle(LAT + 2);
      done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("all_done", {done[0], done[1], done[2]}, 3'b111);
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
